// File: rtl/add_share_pkg.sv
// -----------------------------------------------------------------------------
// add_share_pkg
//   Shared constants, the result-slot state encoding and a one-hot to index
//   helper for the shared-adder controller.
//
//   Contents:
//     ADD_W    operand / result width (32)
//     MAX_REQ  largest supported requester count (4)
//     ID_W     requester index width (2)
//     state_e  result slot state: EMPTY (no result held) / FULL (result held)
//     onehot_to_idx()  converts a one-hot grant vector to its index
// -----------------------------------------------------------------------------
package add_share_pkg;

  localparam int ADD_W   = 32;
  localparam int MAX_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Returns the position of the set bit; an all-zero vector maps to 0.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/add_share_adder.sv
// -----------------------------------------------------------------------------
// add_share_adder
//   Plain combinational 32-bit adder. The carry out is discarded, so the sum
//   wraps modulo 2^32.
//
//   Ports:
//     a    in   ADD_W  operand A
//     b    in   ADD_W  operand B
//     sum  out  ADD_W  a + b modulo 2^ADD_W
// -----------------------------------------------------------------------------
module add_share_adder
  import add_share_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  output logic [ADD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/add_share_arb.sv
// -----------------------------------------------------------------------------
// add_share_arb
//   Picks at most one requester to use the shared adder. No requester is
//   granted while the result slot is occupied and not being drained.
//
//   Configuration macro: ADD_SHARE_RR_EN
//     defined   -> round-robin; the search starts at pointer+1 mod NUM_REQ
//     undefined -> fixed priority, lowest index wins (no pointer port)
//
//   Ports:
//     req_valid  in   NUM_REQ  per-requester operation valid
//     slot_free  in   1        result slot can accept a new result this cycle
//     pointer    in   ID_W     last granted index (round-robin build only)
//     grant      out  NUM_REQ  one-hot or zero grant
// -----------------------------------------------------------------------------
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               slot_free,
`ifdef ADD_SHARE_RR_EN
  input  logic [ID_W-1:0]    pointer,
`endif
  output logic [NUM_REQ-1:0] grant
);

`ifdef ADD_SHARE_RR_EN
  logic found;

  // NOTE: every variable written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    // Walk the requesters in order pointer+1, pointer+2, ... wrapping; the
    // first valid one seen wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(pointer) + k) % NUM_REQ)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    if (!slot_free) grant = '0;
  end
`else
  // Isolate the lowest set bit: x & -x.
  assign grant = slot_free ? (req_valid & (~req_valid + NUM_REQ'(1))) : '0;
`endif

endmodule

// File: rtl/add_share_ctrl.sv
// -----------------------------------------------------------------------------
// add_share_ctrl
//   Shares one 32-bit adder between NUM_REQ requesters. A granted operand pair
//   is summed and captured in a single result register (latency 1); a new
//   grant may coincide with the result being drained, giving one op/cycle.
//
//   Configuration macro: ADD_SHARE_RR_EN (round-robin arbitration when
//   defined, fixed lowest-index priority otherwise).
//
//   Ports:
//     clk        in   1            clock, all state on rising edge
//     rst_n      in   1            asynchronous active-low reset
//     req_valid  in   NUM_REQ      per-requester operation valid
//     req_ready  out  NUM_REQ      per-requester grant, one-hot or zero
//     req_a      in   32*NUM_REQ   operand A, requester i at [32i+31:32i]
//     req_b      in   32*NUM_REQ   operand B, same packing
//     rsp_valid  out  1            result register holds an unconsumed result
//     rsp_ready  in   1            consumer accepts the result
//     rsp_data   out  32           registered sum modulo 2^32
//     rsp_id     out  2            requester that owns rsp_data
// -----------------------------------------------------------------------------
module add_share_ctrl
  import add_share_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [ADD_W*NUM_REQ-1:0] req_a,
  input  logic [ADD_W*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADD_W-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id
);

  state_e              state_q, state_d;
  logic                slot_free;
  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic [ID_W-1:0]     grant_idx;
  logic [ADD_W-1:0]    sel_a, sel_b, sum;

  assign rsp_valid = (state_q == FULL);

  // Gating with rst_n keeps req_ready low for the whole reset, even though
  // the slot reads as empty then.
  assign slot_free = rst_n & (~rsp_valid | rsp_ready);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ADD_SHARE_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Reset value NUM_REQ-1 makes requester 0 the first one searched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rr_ptr <= ID_W'(NUM_REQ - 1);
    else if (grant_any) rr_ptr <= grant_idx;
  end

  add_share_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .slot_free (slot_free),
    .pointer   (rr_ptr),
    .grant     (grant)
  );
`else
  add_share_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (req_valid),
    .slot_free (slot_free),
    .grant     (grant)
  );
`endif

  assign req_ready = grant;
  assign grant_any = |grant;
  assign grant_idx = onehot_to_idx(MAX_REQ'(grant));

  // ---------------------------------------------------------------------------
  // Operand select and shared adder
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[ADD_W*i +: ADD_W];
        sel_b = req_b[ADD_W*i +: ADD_W];
      end
    end
  end

  add_share_adder u_adder (
    .a   (sel_a),
    .b   (sel_b),
    .sum (sum)
  );

  // ---------------------------------------------------------------------------
  // Result slot FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (grant_any) state_d = FULL;
      FULL: begin
        // A grant only happens here when rsp_ready drains the old result in
        // the same cycle, so the slot stays FULL with the new sum.
        if (grant_any)      state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs at the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_any) begin
        rsp_data <= sum;
        rsp_id   <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_add_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_share_ctrl
//   Directed bench for add_share_ctrl (NUM_REQ=2). The driver pushes the
//   hand-computed {id, sum} of each expected grant into a queue; a monitor
//   pops and compares on every response handshake. Expected grant order
//   follows ADD_SHARE_RR_EN.
// -----------------------------------------------------------------------------
module tb_add_share_ctrl;

  localparam int NUM_REQ = 2;
`ifdef ADD_SHARE_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_data;
  logic [1:0]            rsp_id;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];

  add_share_ctrl #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got id=%0d data=0x%08h expected none", rsp_id, rsp_data);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  // One cycle of stimulus: apply inputs, check req_ready mid-cycle, record the
  // expected result when a grant is expected, return at posedge+1.
  task automatic drive(input string name, input logic [1:0] v,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr, input logic [1:0] exp_rdy,
                       input logic [1:0] eid, input logic [31:0] edata);
    rsp_t e;
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rr;
    @(negedge clk);
    check(name, 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != 2'b00) begin
      e.id   = eid;
      e.data = edata;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  eid;
    logic [31:0] edata;

    // ---- reset --------------------------------------------------------------
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;

    // ---- single op, granted on the first edge after release ----------------
    drive("single_rdy", 2'b01, 32'h5, 32'h7, 32'h0, 32'h0, 1'b1, 2'b01, 2'd0, 32'h0000_000C);
    check("single_valid", 64'(rsp_valid), 64'd1);

    // ---- wrap-around addition ---------------------------------------------
    drive("wrap_rdy", 2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h2, 1'b1, 2'b10, 2'd1, 32'h0000_0001);
    drive("idle_rdy", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 2'd0, 32'h0);
    check("idle_valid", 64'(rsp_valid), 64'd0);

    // ---- contention, one result per cycle -----------------------------------
    for (int i = 0; i < 4; i++) begin
      eid   = RR ? 2'(i % 2) : 2'd0;
      edata = (eid == 2'd0) ? 32'(10 + i) : 32'(100 + i);
      drive("contend_rdy", 2'b11, 32'(i), 32'd10, 32'(100 + i), 32'd0, 1'b1,
            (eid == 2'd0) ? 2'b01 : 2'b10, eid, edata);
      check("contend_valid", 64'(rsp_valid), 64'd1);
    end
    drive("drain_rdy", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 2'd0, 32'h0);

    // ---- backpressure -------------------------------------------------------
    drive("bp_grant", 2'b01, 32'h1000, 32'h234, 32'h0, 32'h0, 1'b0, 2'b01, 2'd0, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      drive("bp_rdy", 2'b11, 32'h1, 32'h1, 32'h2, 32'h2, 1'b0, 2'b00, 2'd0, 32'h0);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data",  64'(rsp_data),  64'h1234);
      check("bp_id",    64'(rsp_id),    64'd0);
    end
    // Releasing rsp_ready grants in the same cycle the held result drains.
    if (RR) drive("bp_resume", 2'b11, 32'h1, 32'h1, 32'h2, 32'h2, 1'b1, 2'b10, 2'd1, 32'h4);
    else    drive("bp_resume", 2'b11, 32'h1, 32'h1, 32'h2, 32'h2, 1'b1, 2'b01, 2'd0, 32'h2);
    drive("bp_drain", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 2'd0, 32'h0);

    // ---- reset mid-operation ------------------------------------------------
    // This result is discarded by reset, so nothing is queued for it.
    req_valid = 2'b01;
    req_a     = {32'h0, 32'h1234};
    req_b     = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_rdy", 64'(req_ready), 64'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("full_valid", 64'(rsp_valid), 64'd1);
    check("full_data",  64'(rsp_data),  64'h1234);
    #2;
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check("async_valid", 64'(rsp_valid), 64'd0);
    check("async_data",  64'(rsp_data),  64'd0);
    check("async_rdy",   64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive("post_rst", 2'b11, 32'h20, 32'h3, 32'h40, 32'h5, 1'b1, 2'b01, 2'd0, 32'h23);
    drive("post_idle", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b00, 2'd0, 32'h0);
    repeat (2) @(posedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
